// File: rtl/draw_pkg.sv
// Shared types and PS/2 scan-code constants for the drawing-grid controller.
package draw_pkg;

  localparam int GRID_W_DEF = 28;
  localparam int GRID_H_DEF = 28;

  typedef enum logic [2:0] {ST_IDLE, ST_EXT, ST_BRK, ST_PAINT, ST_CLEAR} state_t;
  typedef enum logic [1:0] {DIR_LEFT, DIR_RIGHT, DIR_UP, DIR_DOWN} dir_t;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_SPACE = 8'h29;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_LEFT) || (code == SC_RIGHT) || (code == SC_UP) || (code == SC_DOWN);
  endfunction

  function automatic dir_t arrow_dir(input logic [7:0] code);
    case (code)
      SC_RIGHT: return DIR_RIGHT;
      SC_UP:    return DIR_UP;
      SC_DOWN:  return DIR_DOWN;
      default:  return DIR_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/ps2_code_filter.sv
// Decodes one accepted scan byte against the current prefix state (IDLE/EXT/BRK)
// into a one-cycle move/paint command and the prefix state that follows it.
module ps2_code_filter
  import draw_pkg::*;
(
  input  state_t      state,
  input  logic [7:0]  scan_byte,
  input  logic        accept,
  output logic        cmd_valid,
  output logic        cmd_move,
  output dir_t        cmd_dir,
  output state_t      next_prefix
);

  // NOTE: every output gets a default first so this block never infers a latch.
  always_comb begin
    cmd_valid   = 1'b0;
    cmd_move    = 1'b0;
    cmd_dir     = DIR_LEFT;
    next_prefix = ST_IDLE;
    if (accept) begin
      case (state)
        ST_IDLE: begin
          if (scan_byte == SC_EXT) begin
            next_prefix = ST_EXT;
          end else if (scan_byte == SC_BRK) begin
            next_prefix = ST_BRK;
          end else if (is_arrow(scan_byte)) begin
            cmd_valid = 1'b1;
            cmd_move  = 1'b1;
            cmd_dir   = arrow_dir(scan_byte);
          end else if (scan_byte == SC_SPACE) begin
            cmd_valid = 1'b1;
          end
        end
        ST_EXT: begin
          if (scan_byte == SC_BRK) begin
            next_prefix = ST_BRK;
          end else if (is_arrow(scan_byte)) begin
            cmd_valid = 1'b1;
            cmd_move  = 1'b1;
            cmd_dir   = arrow_dir(scan_byte);
          end
        end
        // A byte after F0 is the key release: swallowed, back to IDLE.
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_draw_controller.sv
// Arrow-key cursor and paint/clear writer for the 28x28 NN input-image buffer.
// Define DRAW_BRUSH_2X2_EN to paint a clamped 2x2 block instead of one pixel.
module ps2_draw_controller
  import draw_pkg::*;
#(
  parameter int               GRID_W  = GRID_W_DEF,
  parameter int               GRID_H  = GRID_H_DEF,
  parameter int               ADDR_W  = 10,
  parameter int               PIX_W   = 8,
  parameter logic [PIX_W-1:0] INK     = 8'hFF,
  parameter int               START_X = 13,
  parameter int               START_Y = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        scan_byte,
  input  logic              scan_valid,
  output logic              scan_ready,
  input  logic              draw_en,
  input  logic              erase,
  input  logic              clear_req,
  output logic              busy,
  output logic [4:0]        cursor_x,
  output logic [4:0]        cursor_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data
);

  localparam logic [4:0]        X_MAX    = 5'(GRID_W - 1);
  localparam logic [4:0]        Y_MAX    = 5'(GRID_H - 1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(GRID_W * GRID_H - 1);

  // Row offset y*28 as a sum of shifts, so no multiplier is inferred.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] x, input logic [4:0] y);
    logic [ADDR_W-1:0] yy;
    yy = ADDR_W'(y);
    return (yy << 4) + (yy << 3) + (yy << 2) + ADDR_W'(x);
  endfunction

  state_t     state;
  state_t     next_prefix;
  logic       accept;
  logic       cmd_valid;
  logic       cmd_move;
  dir_t       cmd_dir;
  logic [4:0] nx;
  logic [4:0] ny;

`ifdef DRAW_BRUSH_2X2_EN
  logic [1:0] phase;
  logic [4:0] x1;
  logic [4:0] y1;
  assign x1 = (cursor_x == X_MAX) ? cursor_x : cursor_x + 5'd1;
  assign y1 = (cursor_y == Y_MAX) ? cursor_y : cursor_y + 5'd1;
`endif

  // scan_ready is high exactly in IDLE/EXT/BRK, and clear_req wins over a byte.
  assign accept = scan_valid && scan_ready && !clear_req;

  ps2_code_filter u_filter (
    .state       (state),
    .scan_byte   (scan_byte),
    .accept      (accept),
    .cmd_valid   (cmd_valid),
    .cmd_move    (cmd_move),
    .cmd_dir     (cmd_dir),
    .next_prefix (next_prefix)
  );

  // Saturating next cursor; a space command leaves it in place.
  always_comb begin
    nx = cursor_x;
    ny = cursor_y;
    if (cmd_move) begin
      case (cmd_dir)
        DIR_LEFT:  if (cursor_x != 5'd0)  nx = cursor_x - 5'd1;
        DIR_RIGHT: if (cursor_x != X_MAX) nx = cursor_x + 5'd1;
        DIR_UP:    if (cursor_y != 5'd0)  ny = cursor_y - 5'd1;
        default:   if (cursor_y != Y_MAX) ny = cursor_y + 5'd1;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // here sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cursor_x   <= 5'(START_X);
      cursor_y   <= 5'(START_Y);
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      scan_ready <= 1'b1;
`ifdef DRAW_BRUSH_2X2_EN
      phase      <= 2'd0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_EXT, ST_BRK: begin
          if (clear_req) begin
            state      <= ST_CLEAR;
            busy       <= 1'b1;
            scan_ready <= 1'b0;
            wr_en      <= 1'b1;
            wr_addr    <= '0;
            wr_data    <= '0;
          end else if (accept) begin
            if (cmd_valid) begin
              cursor_x <= nx;
              cursor_y <= ny;
              wr_addr  <= addr_of(nx, ny);
              if (draw_en) begin
                state      <= ST_PAINT;
                scan_ready <= 1'b0;
                wr_en      <= 1'b1;
                wr_data    <= erase ? '0 : INK;
`ifdef DRAW_BRUSH_2X2_EN
                phase      <= 2'd0;
`endif
              end else begin
                state <= ST_IDLE;
              end
            end else begin
              state <= next_prefix;
            end
          end
        end
        ST_PAINT: begin
`ifdef DRAW_BRUSH_2X2_EN
          phase <= phase + 2'd1;
          case (phase)
            2'd0:    wr_addr <= addr_of(x1, cursor_y);
            2'd1:    wr_addr <= addr_of(cursor_x, y1);
            2'd2:    wr_addr <= addr_of(x1, y1);
            default: begin
              wr_en      <= 1'b0;
              wr_addr    <= addr_of(cursor_x, cursor_y);
              scan_ready <= 1'b1;
              state      <= ST_IDLE;
            end
          endcase
`else
          wr_en      <= 1'b0;
          scan_ready <= 1'b1;
          state      <= ST_IDLE;
`endif
        end
        ST_CLEAR: begin
          if (wr_addr == CLR_LAST) begin
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            scan_ready <= 1'b1;
            wr_addr    <= addr_of(cursor_x, cursor_y);
            state      <= ST_IDLE;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end
        default: begin
          wr_en      <= 1'b0;
          busy       <= 1'b0;
          scan_ready <= 1'b1;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_draw_controller.md
Name: ps2_draw_controller

Overview:
- Sits between the PS/2 scan-byte receiver and the 28x28 input-image buffer that feeds the neural-network core.
- Decodes arrow-key make codes into cursor moves on the drawing grid.
- When drawing is enabled, paints or erases each pixel it lands on through a single-port write interface.
- Also sweeps a full-buffer clear on request, so a new digit can be drawn before inference is started.

Parameters:
- GRID_W, 28, grid width in pixels.
- GRID_H, 28, grid height in pixels.
- ADDR_W, 10, image-buffer address width (must satisfy GRID_W*GRID_H <= 2^ADDR_W).
- PIX_W, 8, pixel data width.
- INK, 8'hFF, value written when painting (erase writes 0).
- START_X, 13, reset column of the cursor.
- START_Y, 13, reset row of the cursor.

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- scan_byte  in  8  PS/2 scan byte from receiver
- scan_valid  in  1  one-cycle strobe qualifying scan_byte
- scan_ready  out  1  high when a byte can be consumed
- draw_en  in  1  level; 1 = movement paints
- erase  in  1  level; 1 = paint with 0 instead of INK
- clear_req  in  1  one-cycle pulse; start buffer clear
- busy  out  1  high during the CLEAR sweep
- cursor_x  out  5  current column
- cursor_y  out  5  current row
- wr_en  out  1  image-buffer write strobe
- wr_addr  out  ADDR_W  write address = cursor_y*GRID_W + cursor_x
- wr_data  out  PIX_W  write data

Behaviour:
- Reset values (synchronous, active-high):
  - state=IDLE; cursor=(START_X, START_Y); wr_en=0; wr_addr=0; wr_data=0; busy=0; scan_ready=1.
  - Reset mid-CLEAR or mid-PAINT aborts immediately; no further writes.
- States: IDLE, EXT, BRK, PAINT, CLEAR.
- scan_ready=1 only in IDLE, EXT and BRK. A scan_valid strobe in any other state is dropped, with no side effects.
- IDLE:
  - 8'hE0 -> EXT.
  - 8'hF0 -> BRK.
  - Arrow code -> move.
  - 8'h29 (space) -> paint in place with no move.
  - Any other byte is ignored.
- EXT:
  - 8'hF0 -> BRK.
  - Arrow code -> move.
  - Any other byte -> IDLE.
- BRK: the next byte is discarded (key release) -> IDLE.
- Arrow codes, each accepted with or without the E0 prefix:
  - 6B = left (x-1)
  - 74 = right (x+1)
  - 75 = up (y-1)
  - 72 = down (y+1)
- Moves saturate at 0 and at GRID_W-1 / GRID_H-1; there is no wrap-around. A blocked move still counts as a move, so it still paints.
- Timing: a byte accepted on the edge ending cycle t makes the new cursor visible in cycle t+1.
  - If draw_en=1 at acceptance: state=PAINT; wr_en=1 for exactly cycle t+1, with the new wr_addr and wr_data=(erase?0:INK); then -> IDLE.
  - If draw_en=0: no write; -> IDLE directly.
- Address arithmetic: cursor_y*28 is computed as (y<<4)+(y<<3)+(y<<2), zero-extended to ADDR_W. It is registered together with the cursor.
- clear_req is sampled in IDLE, EXT or BRK only (ignored in PAINT or CLEAR).
  - It takes priority over a simultaneous scan_valid; that byte is dropped.
  - It enters CLEAR with busy=1, then writes 0 to addresses 0..GRID_W*GRID_H-1 on consecutive cycles (784 cycles, wr_en continuously high).
  - It then returns to IDLE with busy=0. The cursor is unchanged.
- wr_en is never high outside PAINT or CLEAR.

Optional Feature:
- Macro: DRAW_BRUSH_2X2_EN.
- Defined:
  - PAINT writes a 2x2 block over 4 consecutive cycles: (x,y), (x+1,y), (x,y+1), (x+1,y+1).
  - Coordinates are clamped to the grid, so at an edge the same address may repeat.
  - scan_ready stays 0 for all 4 cycles.
- Undefined: single-pixel, 1-cycle PAINT as described above.

Decomposition:
- Package draw_pkg:
  - State enum.
  - Scan-code constants: SC_EXT=E0, SC_BRK=F0, SC_LEFT=6B, SC_RIGHT=74, SC_UP=75, SC_DOWN=72, SC_SPACE=29.
  - GRID_W/GRID_H defaults.
- One natural sub-module, ps2_code_filter: handles the E0/F0 prefix tracking and emits a one-cycle move/paint command plus a direction. The FSM and address logic remain in the parent.

Test Plan:
- Reset, then byte 74 with draw_en=1, erase=0 -> cursor (14,13); one wr_en cycle, wr_addr=378, wr_data=FF.
- Bytes F0,74 -> no cursor change, no write. Bytes E0,72 -> cursor (13,14), wr_addr=405.
- 20 x byte 6B with draw_en=1 from reset -> cursor_x saturates at 0; final wr_addr=364; no wrap to 27.
- clear_req pulse -> busy high for 784 cycles, wr_addr 0..783 ascending, wr_data=0. A scan byte during the sweep is dropped (cursor unchanged).
- Byte 29 with erase=1 -> one write at the current address with data 00. Byte 74 with draw_en=0 -> cursor moves, wr_en stays 0.
- Reset asserted mid-CLEAR at address 100 -> next cycle wr_en=0, busy=0, cursor=(13,13). With DRAW_BRUSH_2X2_EN, byte 74 from reset -> writes at 378, 379, 406, 407.
